// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: FIFO-read and serial-line bundle of the UART TX stage.
// Signals:
//   fifo_empty, fifo_data : upstream FIFO status and read data (valid the cycle after fifo_rd_en)
//   fifo_rd_en            : one-cycle pop request to the FIFO
//   txd, tx_busy, tx_done : serial line and frame status
// Modports:
//   master = the serializer, slave = the FIFO/line side.

interface uart_tx_serializer_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       txd;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en,
        output txd,
        output tx_busy,
        output tx_done
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en,
        input  txd,
        input  tx_busy,
        input  tx_done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops one byte from the TX FIFO when idle and sends it as
// start + 8 data bits (LSB first) + optional parity + STOP_BITS stop bits.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : uart_tx_serializer_if.master
//         (fifo_empty, fifo_data in; fifo_rd_en, txd, tx_busy, tx_done out)
// Parameters:
//   CLKS_PER_BIT : clk cycles per bit (2..65535)
//   STOP_BITS    : 1 or 2
//   PARITY_ODD   : 0 = even, 1 = odd
// Optional feature: define UART_PARITY_EN to insert the parity bit.

module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_tx_serializer_if.master   bus
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        PARITY_ODD > 1) begin : g_bad_params
        $error("uart_tx_serializer: illegal parameter value");
    end

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_START, S_DATA, S_STOP
    } state_t;
`endif

    state_t        state, state_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shreg, shreg_n;
    logic          stop_cnt, stop_n;
    logic          txd_q, txd_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;
    logic          rd_en;
    logic          bit_end;
`ifdef UART_PARITY_EN
    logic          par, par_n;
`endif

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        stop_n  = stop_cnt;
`ifdef UART_PARITY_EN
        par_n   = par;
`endif
        rd_en   = 1'b0;
        bit_end = (baud_cnt == BAUD_LAST);

        unique case (state)
            S_IDLE: begin
                // Gated by rst so no pop is issued while reset is held.
                if (!bus.fifo_empty && !rst) begin
                    rd_en   = 1'b1;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                shreg_n = bus.fifo_data;
`ifdef UART_PARITY_EN
                par_n   = (^bus.fifo_data) ^ (PARITY_ODD != 0);
`endif
                baud_n  = '0;
                bit_n   = '0;
                stop_n  = 1'b0;
                state_n = S_START;
            end
            S_START: begin
                if (bit_end) state_n = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        bit_n   = bit_cnt + 3'd1;
                        shreg_n = {1'b0, shreg[7:1]};
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_n = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (stop_cnt == STOP_LAST) state_n = S_IDLE;
                    else stop_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (state != S_IDLE && state != S_FETCH)
            baud_n = bit_end ? '0 : baud_cnt + 1'b1;

        // Outputs are registered from the next state so txd lines up
        // with the bit the state machine is entering.
        case (state_n)
            S_START:  txd_n = 1'b0;
            S_DATA:   txd_n = shreg_n[0];
`ifdef UART_PARITY_EN
            S_PARITY: txd_n = par_n;
`endif
            default:  txd_n = 1'b1;
        endcase
        busy_n = (state_n != S_IDLE);
        done_n = (state_n == S_STOP) && (baud_n == BAUD_LAST) &&
                 (stop_n == STOP_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            stop_cnt <= 1'b0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            stop_cnt <= stop_n;
            txd_q    <= txd_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
`ifdef UART_PARITY_EN
            par      <= par_n;
`endif
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.txd        = txd_q;
    assign bus.tx_busy    = busy_q;
    assign bus.tx_done    = done_q;

endmodule
